// File: rtl/game_pkg.sv
// Shared definitions for the frame-synchronous game controller:
// state encodings, BCD digit width and score ceiling.
package game_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam int unsigned MAX_SCORE = 99;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t MAX_D1 = bcd_t'(MAX_SCORE / 10);
  localparam bcd_t MAX_D0 = bcd_t'(MAX_SCORE % 10);

  typedef enum logic [1:0] {
    ST_ATTRACT  = 2'd0,
    ST_PLAY     = 2'd1,
    ST_DYING    = 2'd2,
    ST_GAMEOVER = 2'd3
  } game_state_e;

  // Two-digit BCD greater-than, tens digit compared first.
  function automatic logic bcd2_gt(input bcd_t a1, input bcd_t a0,
                                   input bcd_t b1, input bcd_t b0);
    return (a1 > b1) || ((a1 == b1) && (a0 > b0));
  endfunction

endpackage

// File: rtl/game_state_ctrl_bcd2_sat_inc.sv
// Two-digit BCD incrementer that holds at the package score ceiling.
module bcd2_sat_inc
  import game_pkg::*;
(
  input  logic             inc,
  input  logic [BCD_W-1:0] d0_i,
  input  logic [BCD_W-1:0] d1_i,
  output logic [BCD_W-1:0] d0_o,
  output logic [BCD_W-1:0] d1_o
);

  always_comb begin
    d0_o = d0_i;
    d1_o = d1_i;
    if (inc && !((d1_i == MAX_D1) && (d0_i == MAX_D0))) begin
      if (d0_i == bcd_t'(9)) begin
        d0_o = '0;
        d1_o = d1_i + bcd_t'(1);
      end else begin
        d0_o = d0_i + bcd_t'(1);
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game controller: latches hit/miss/start events per frame and applies them
// at the vsync rising edge. Define HISCORE_EN to build the high-score register.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             vsync,
  input  logic             start_btn,
  input  logic             hit_evt,
  input  logic             miss_evt,
  output logic [BCD_W-1:0] score0,
  output logic [BCD_W-1:0] score1,
  output logic [3:0]       lives,
  output logic [1:0]       state,
  output logic             playfield_en,
  output logic [BCD_W-1:0] hi0,
  output logic [BCD_W-1:0] hi1
);

  logic             vsync_q;
  logic             sync1_q, sync2_q, sync3_q;
  logic             start_pend_q, start_pend_d;
  logic             hit_pend_q, hit_pend_d;
  logic             miss_pend_q, miss_pend_d;
  game_state_e      state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] score0_q, score0_d, score1_q, score1_d;
  logic [3:0]       lives_q, lives_d;

  logic             tick;
  logic             start_edge;
  logic [3:0]       lives_left;
  logic [BCD_W-1:0] inc0, inc1;

  bcd2_sat_inc u_score_inc (
    .inc  (hit_pend_q),
    .d0_i (score0_q),
    .d1_i (score1_q),
    .d0_o (inc0),
    .d1_o (inc1)
  );

  always_comb begin
    tick       = vsync & ~vsync_q;
    start_edge = sync2_q & ~sync3_q;

    // A pulse landing in the tick cycle survives the clear and counts next frame.
    hit_pend_d   = tick ? hit_evt    : (hit_pend_q   | hit_evt);
    miss_pend_d  = tick ? miss_evt   : (miss_pend_q  | miss_evt);
    start_pend_d = tick ? start_edge : (start_pend_q | start_edge);

    state_d    = state_q;
    cnt_d      = cnt_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    lives_d    = lives_q;
    lives_left = (lives_q != 4'd0) ? (lives_q - 4'd1) : 4'd0;

    if (tick) begin
      unique case (state_q)
        ST_ATTRACT: begin
          if (start_pend_q) begin
            state_d  = ST_PLAY;
            score0_d = '0;
            score1_d = '0;
            lives_d  = 4'(INIT_LIVES);
          end
        end
        ST_PLAY: begin
          score0_d = inc0;
          score1_d = inc1;
          if (miss_pend_q) begin
            state_d = ST_DYING;
            cnt_d   = 8'(DEATH_FRAMES);
          end
        end
        ST_DYING: begin
          if (cnt_q == 8'd1) begin
            lives_d = lives_left;
            if (lives_left == 4'd0) begin
              state_d = ST_GAMEOVER;
              cnt_d   = 8'(OVER_FRAMES);
            end else begin
              state_d = ST_PLAY;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_GAMEOVER: begin
          if (start_pend_q) begin
            state_d  = ST_PLAY;
            cnt_d    = '0;
            score0_d = '0;
            score1_d = '0;
            lives_d  = 4'(INIT_LIVES);
          end else if (cnt_q == 8'd1) begin
            state_d = ST_ATTRACT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_ATTRACT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      vsync_q      <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      start_pend_q <= 1'b0;
      hit_pend_q   <= 1'b0;
      miss_pend_q  <= 1'b0;
      state_q      <= ST_ATTRACT;
      cnt_q        <= '0;
      score0_q     <= '0;
      score1_q     <= '0;
      lives_q      <= 4'(INIT_LIVES);
    end else begin
      vsync_q      <= vsync;
      sync1_q      <= start_btn;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      start_pend_q <= start_pend_d;
      hit_pend_q   <= hit_pend_d;
      miss_pend_q  <= miss_pend_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      lives_q      <= lives_d;
    end
  end

`ifdef HISCORE_EN
  logic [BCD_W-1:0] hi0_q, hi0_d, hi1_q, hi1_d;

  // Captured on the DYING->GAMEOVER edge so it lands with the state change.
  always_comb begin
    hi0_d = hi0_q;
    hi1_d = hi1_q;
    if ((state_q == ST_DYING) && (state_d == ST_GAMEOVER) &&
        bcd2_gt(score1_q, score0_q, hi1_q, hi0_q)) begin
      hi0_d = score0_q;
      hi1_d = score1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      hi0_q <= '0;
      hi1_q <= '0;
    end else begin
      hi0_q <= hi0_d;
      hi1_q <= hi1_d;
    end
  end

  assign hi0 = hi0_q;
  assign hi1 = hi1_q;
`else
  assign hi0 = '0;
  assign hi1 = '0;
`endif

  assign score0       = score0_q;
  assign score1       = score1_q;
  assign lives        = lives_q;
  assign state        = state_q;
  assign playfield_en = (state_q == ST_PLAY);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl against a frame-level behavioural model.
module tb_game_state_ctrl;

  localparam int INIT_L = 3;
  localparam int DF     = 4;
  localparam int OF     = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       vsync = 1'b0, start_btn = 1'b0, hit_evt = 1'b0, miss_evt = 1'b0;
  logic [3:0] score0, score1, lives, hi0, hi1;
  logic [1:0] state;
  logic       playfield_en;

  always #5 CLK = ~CLK;

  game_state_ctrl #(
    .INIT_LIVES  (INIT_L),
    .DEATH_FRAMES(DF),
    .OVER_FRAMES (OF)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .vsync       (vsync),
    .start_btn   (start_btn),
    .hit_evt     (hit_evt),
    .miss_evt    (miss_evt),
    .score0      (score0),
    .score1      (score1),
    .lives       (lives),
    .state       (state),
    .playfield_en(playfield_en),
    .hi0         (hi0),
    .hi1         (hi1)
  );

  logic [22:0] obs;
  assign obs = {state, score1, score0, lives, playfield_en, hi1, hi0};

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model: state as 0..3, score and high score as decimal integers.
  int m_state, m_score, m_lives, m_hi, m_frames_left;
  bit m_hit_carry;

  function automatic logic [22:0] exp_vec();
    int h;
    h = 0;
`ifdef HISCORE_EN
    h = m_hi;
`endif
    return {2'(m_state), 4'(m_score / 10), 4'(m_score % 10), 4'(m_lives),
            (m_state == 1), 4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = INIT_L; m_hi = 0;
    m_frames_left = 0; m_hit_carry = 0;
  endtask

  task automatic model_frame(input bit hp, input bit mp, input bit sp);
    case (m_state)
      0: if (sp) begin m_state = 1; m_score = 0; m_lives = INIT_L; end
      1: begin
        if (hp && m_score < 99) m_score++;
        if (mp) begin m_state = 2; m_frames_left = DF; end
      end
      2: begin
        m_frames_left--;
        if (m_frames_left == 0) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          if (m_lives == 0) begin
            m_state = 3; m_frames_left = OF;
            if (m_score > m_hi) m_hi = m_score;
          end else m_state = 1;
        end
      end
      default: begin
        if (sp) begin m_state = 1; m_score = 0; m_lives = INIT_L; end
        else begin
          m_frames_left--;
          if (m_frames_left == 0) m_state = 0;
        end
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // One frame of events followed by a vsync rising edge; tick_hit puts a hit in the tick cycle.
  task automatic run_frame(input int hits, input bit miss, input bit start, input bit tick_hit);
    bit hp;
    if (start) begin
      start_btn = 1'b1; cyc(); cyc(); start_btn = 1'b0;
    end
    for (int i = 0; i < hits; i++) begin
      hit_evt = 1'b1; cyc(); hit_evt = 1'b0; cyc();
    end
    if (miss) begin
      miss_evt = 1'b1; cyc(); miss_evt = 1'b0;
    end
    repeat (4 + $urandom_range(0, 2)) cyc();
    vsync = 1'b1; hit_evt = tick_hit; cyc(); hit_evt = 1'b0;
    hp = (hits > 0) || m_hit_carry;
    m_hit_carry = tick_hit;
    model_frame(hp, miss, start);
    cyc(); vsync = 1'b0; cyc();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (4) cyc();
    model_reset();
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", obs, exp_vec());
    end
    RST = 1'b1;
    cyc();
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_start_scoring();
    run_frame(0, 0, 1, 0);
    vectors++;
    if (obs !== exp_vec() || state !== 2'd1 || lives !== 4'd3) begin
      miscompares++;
      $display("FAIL start_to_play: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < 12; i++) begin
      run_frame(1, 0, 0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_hit_frame %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if ({score1, score0} !== 8'h12) begin
      miscompares++;
      $display("FAIL score_after_12: got %h expected 12", {score1, score0});
    end
    run_frame(3, 0, 0, 0);
    vectors++;
    if (obs !== exp_vec() || {score1, score0} !== 8'h13) begin
      miscompares++;
      $display("FAIL multi_hit_frame: got %h expected %h", obs, exp_vec());
    end
    run_frame(0, 0, 0, 1);
    vectors++;
    if (obs !== exp_vec() || {score1, score0} !== 8'h13) begin
      miscompares++;
      $display("FAIL tick_cycle_hit_deferred: got %h expected %h", obs, exp_vec());
    end
    run_frame(0, 0, 0, 0);
    vectors++;
    if (obs !== exp_vec() || {score1, score0} !== 8'h14) begin
      miscompares++;
      $display("FAIL tick_cycle_hit_next_frame: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 105; i++) begin
      run_frame(1, 0, 0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL saturate_frame %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if ({score1, score0} !== 8'h99) begin
      miscompares++;
      $display("FAIL saturate_99: got %h expected 99", {score1, score0});
    end
  endtask

  task automatic test_death();
    run_frame(0, 1, 0, 0);
    vectors++;
    if (obs !== exp_vec() || state !== 2'd2 || playfield_en !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_dying: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < DF; i++) begin
      run_frame(2, 0, 0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL dying_frame %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (state !== 2'd1 || lives !== 4'd2 || {score1, score0} !== 8'h99) begin
      miscompares++;
      $display("FAIL after_death: got %h expected state 1 lives 2 score 99", obs);
    end
  endtask

  task automatic test_gameover();
    RST = 1'b0; cyc(); RST = 1'b1; model_reset();
    run_frame(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) run_frame(1, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      for (int d = 0; d < INIT_L; d++) begin
        run_frame(0, 1, 0, 0);
        for (int i = 0; i < DF; i++) begin
          run_frame(0, 0, 0, 0);
          vectors++;
          if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL death_seq g%0d d%0d f%0d: got %h expected %h", g, d, i, obs, exp_vec());
          end
        end
      end
      vectors++;
      if (state !== 2'd3 || lives !== 4'd0) begin
        miscompares++;
        $display("FAIL gameover_reached g%0d: got %h expected state 3 lives 0", g, obs);
      end
      if (g == 0) begin
        for (int i = 0; i < OF; i++) begin
          run_frame(0, 0, 0, 0);
          vectors++;
          if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL over_count %0d: got %h expected %h", i, obs, exp_vec());
          end
        end
        run_frame(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) run_frame(1, 0, 0, 0);
      end
    end
    run_frame(0, 0, 1, 0);
    vectors++;
    if (obs !== exp_vec() || state !== 2'd1 || lives !== 4'd3 || {score1, score0} !== 8'h00) begin
      miscompares++;
      $display("FAIL restart_from_gameover: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1, 1, 0, 0);
    vectors++;
    if (obs !== exp_vec() || state !== 2'd2 || {score1, score0} !== 8'h01) begin
      miscompares++;
      $display("FAIL hit_and_miss_frame: got %h expected %h", obs, exp_vec());
    end
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 0, 0);
    RST = 1'b0; cyc();
    model_reset();
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_mid_dying: got %h expected %h", obs, exp_vec());
    end
    RST = 1'b1; cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      run_frame($urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_frame %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_scoring();
    test_saturation();
    test_death();
    test_gameover();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
